// File: rtl/spi_neopix_hub_pkg.sv
// rtl/spi_neopix_hub_pkg.sv - shared FSM states, status-byte layout and width helper
package spi_neopix_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ERR    = 2'd2
   } state_t;

   // Status byte returned on MISO at the start of every frame
   localparam int BUSY_BIT   = 7;
   localparam int OVR_BIT    = 6;
   localparam int CH_LSB     = 0;
   localparam int CH_FIELD_W = 6;

   // Channel index width; a single channel still needs one bit
   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/spi_neopix_hub_if.sv
// rtl/spi_neopix_hub_if.sv - shared received-byte bus with per-channel valid/ready
interface spi_neopix_hub_if #(
   parameter int NUM_CH = 2
);
   logic [7:0]        byte_o;
   logic [NUM_CH-1:0] byte_valid_o;
   logic [NUM_CH-1:0] byte_ready_i;

   modport master (output byte_o, output byte_valid_o, input byte_ready_i);
   modport slave  (input byte_o, input byte_valid_o, output byte_ready_i);
endinterface

// File: rtl/spi_neopix_hub_stretch.sv
// rtl/spi_neopix_hub_stretch.sv - pulse stretcher for activity LEDs
module activity_stretch #(
   parameter int STRETCH_CYCLES = 5_000_000
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic act_i,
   output logic led_o
);
   localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Reload while active, then hold the LED on until the count drains to zero
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt   <= '0;
         led_o <= 1'b0;
      end else if (act_i) begin
         cnt   <= CNT_W'(STRETCH_CYCLES);
         led_o <= 1'b1;
      end else if (cnt != '0) begin
         cnt   <= cnt - CNT_W'(1);
         led_o <= 1'b1;
      end else begin
         led_o <= 1'b0;
      end
   end
endmodule

// File: rtl/spi_neopix_hub.sv
// rtl/spi_neopix_hub.sv - SPI front end routing bytes to NeoPixel strip channels
module spi_neopix_hub
   import spi_neopix_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 5_000_000
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              sck_i,
   input  logic              mosi_i,
   input  logic [NUM_CH-1:0] ssel_n_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   spi_neopix_hub_if.master  strm,
   output logic [NUM_CH-1:0] frame_start_o,
   output logic [NUM_CH-1:0] frame_end_o,
   input  logic [NUM_CH-1:0] ch_busy_i,
   output logic [NUM_CH-1:0] overrun_o,
   output logic              sel_err_o,
   output logic [NUM_CH-1:0] spi_led_o,
   output logic [NUM_CH-1:0] ws_led_o
);
   localparam int CH_W = ch_w(NUM_CH);

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
      logic [NUM_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [NUM_CH-1:0]      ssel_sync [SYNC_STAGES];
   logic                   sck_d;

   logic              sck_s, mosi_s, sck_rise, sck_fall;
   logic [NUM_CH-1:0] ssel_s;

   state_t            state;
   logic [CH_W-1:0]   ch;
   logic [7:0]        rx;
   logic [2:0]        bit_cnt;
   logic [7:0]        tx;

   logic [7:0]        byte_q;
   logic [NUM_CH-1:0] valid;
   logic [NUM_CH-1:0] overrun;

   logic              any_low, multi_low;
   logic [CH_W-1:0]   low_idx;
   logic [7:0]        status_byte;
   logic [7:0]        rx_next;
   logic              byte_done;
   logic [NUM_CH-1:0] ch_onehot, xfer, valid_kept, ovr_clr;
   logic              can_load;
   logic [NUM_CH-1:0] spi_act;

   // Synchronisers load idle levels on reset so no phantom edge or select appears
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         for (int s = 0; s < SYNC_STAGES; s++) ssel_sync[s] <= '1;
      end else begin
         sck_sync[0]  <= sck_i;
         mosi_sync[0] <= mosi_i;
         ssel_sync[0] <= ssel_n_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sck_sync[s]  <= sck_sync[s-1];
            mosi_sync[s] <= mosi_sync[s-1];
            ssel_sync[s] <= ssel_sync[s-1];
         end
         sck_d <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign ssel_s   = ssel_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   // Classify the synchronised selects: none, exactly one (and which), or several
   always_comb begin
      any_low   = 1'b0;
      multi_low = 1'b0;
      low_idx   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!ssel_s[c]) begin
            if (any_low) multi_low = 1'b1;
            any_low = 1'b1;
            low_idx = CH_W'(c);
         end
      end
   end

   // Status byte for the channel about to open a frame
   always_comb begin
      status_byte                              = '0;
      status_byte[BUSY_BIT]                    = ch_busy_i[low_idx];
      status_byte[OVR_BIT]                     = overrun[low_idx];
      status_byte[CH_LSB +: CH_FIELD_W]        = CH_FIELD_W'(low_idx);
   end

   assign rx_next    = {rx[6:0], mosi_s};
   assign ch_onehot  = onehot(ch);
   assign byte_done  = (state == ACTIVE) && !ssel_s[ch] && sck_rise && (bit_cnt == 3'd7);
   assign xfer       = valid & strm.byte_ready_i;
   assign valid_kept = valid & ~xfer;
   // byte_o is shared, so a new byte may only land when no other byte is still waiting
   assign can_load   = (valid_kept == '0);
   assign ovr_clr    = (state == IDLE && any_low && !multi_low) ? onehot(low_idx) : '0;

   // Frame FSM: select decode, RX/TX shifting, MISO drive and frame pulses
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state         <= IDLE;
         ch            <= '0;
         rx            <= '0;
         bit_cnt       <= '0;
         tx            <= '0;
         miso_o        <= 1'b0;
         miso_oe_o     <= 1'b0;
         frame_start_o <= '0;
         frame_end_o   <= '0;
         sel_err_o     <= 1'b0;
      end else begin
         frame_start_o <= '0;
         frame_end_o   <= '0;
         sel_err_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (multi_low) begin
                  state     <= ERR;
                  sel_err_o <= 1'b1;
               end else if (any_low) begin
                  state         <= ACTIVE;
                  ch            <= low_idx;
                  frame_start_o <= onehot(low_idx);
                  tx            <= status_byte;
                  miso_o        <= status_byte[7];
                  miso_oe_o     <= 1'b1;
                  rx            <= '0;
                  bit_cnt       <= '0;
               end
            end
            ACTIVE: begin
               if (ssel_s[ch]) begin
                  state       <= IDLE;
                  frame_end_o <= ch_onehot;
                  miso_o      <= 1'b0;
                  miso_oe_o   <= 1'b0;
                  rx          <= '0;
                  bit_cnt     <= '0;
               end else begin
                  if (sck_rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                  end
                  if (sck_fall) begin
                     tx     <= {tx[6:0], 1'b0};
                     miso_o <= tx[6];
                  end
               end
            end
            ERR: begin
               if (&ssel_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Byte hand-off to the serialisers; a set of overrun wins over the frame-start clear
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         byte_q  <= '0;
         valid   <= '0;
         overrun <= '0;
      end else begin
         if (byte_done && can_load) begin
            byte_q <= rx_next;
            valid  <= valid_kept | ch_onehot;
         end else begin
            valid  <= valid_kept;
         end
         if (byte_done && !can_load)
            overrun <= (overrun & ~ovr_clr) | ch_onehot;
         else
            overrun <= overrun & ~ovr_clr;
      end
   end

   assign strm.byte_o       = byte_q;
   assign strm.byte_valid_o = valid;
   assign overrun_o         = overrun;

   // Per-channel "selected" activity feeding the SPI LEDs
   always_comb begin
      spi_act = '0;
      for (int c = 0; c < NUM_CH; c++)
         spi_act[c] = (state == ACTIVE) && (ch == CH_W'(c));
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_led
      activity_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_spi_led (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .act_i     (spi_act[c]),
         .led_o     (spi_led_o[c])
      );
      activity_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_ws_led (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .act_i     (ch_busy_i[c]),
         .led_o     (ws_led_o[c])
      );
   end

endmodule
